// File: rtl/alu_cmd_sequencer_if.sv
// Command/response channel bundle for alu_cmd_sequencer.
// master = host side (issues commands, consumes responses); slave = sequencer.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_chain;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_chain, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_chain, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for the accumulator ALU: one op in flight, registered ALU drives.
// Optional ALU_SEQ_CNT_EN adds saturating op_count / err_count outputs.
module alu_cmd_sequencer #(
    parameter int RESULT_LAT = 1,
    parameter int WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    alu_cmd_sequencer_if.slave   bus,
    output logic                 alu_on,
    output logic [2:0]           alu_in_sel,
    output logic [WIDTH-1:0]     alu_num1,
    output logic [WIDTH-1:0]     alu_num2,
    output logic [6:0]           alu_out_sel,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_overflow
`ifdef ALU_SEQ_CNT_EN
    ,
    output logic [15:0]          op_count,
    output logic [7:0]           err_count
`endif
);
    typedef enum logic [2:0] {OFF, IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_CLR = 3'd7;
    localparam logic [2:0] SEL_PERSIST = 3'b100;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_RESET   = 3'b001;

    state_t           state, state_d;
    logic [2:0]       op_q, op_d;
    logic [3:0]       cnt, cnt_d;
    logic             on_d, rv_d, re_d;
    logic [2:0]       in_sel_d;
    logic [6:0]       out_sel_d;
    logic [WIDTH-1:0] num1_d, num2_d, rd_d;

    assign bus.cmd_ready = (state == IDLE) && en;

    always_comb begin
        state_d   = state;
        op_d      = op_q;
        cnt_d     = cnt;
        on_d      = alu_on;
        in_sel_d  = alu_in_sel;
        num1_d    = alu_num1;
        num2_d    = alu_num2;
        out_sel_d = alu_out_sel;
        rv_d      = bus.rsp_valid;
        rd_d      = bus.rsp_data;
        re_d      = bus.rsp_err;
        case (state)
            OFF: begin
                if (en) begin
                    state_d  = IDLE;
                    on_d     = 1'b1;
                    in_sel_d = SEL_PERSIST;
                end
            end
            IDLE: begin
                if (!en) begin
                    state_d = OFF;
                    on_d    = 1'b0;
                end else if (bus.cmd_valid) begin
                    // ALU drives are registered at the accept edge so they are stable throughout ISSUE
                    state_d   = ISSUE;
                    op_d      = bus.cmd_op;
                    num1_d    = bus.cmd_a;
                    num2_d    = bus.cmd_b;
                    if (bus.cmd_op == OP_CLR) begin
                        in_sel_d  = SEL_RESET;
                        out_sel_d = '0;
                    end else begin
                        in_sel_d  = bus.cmd_chain ? SEL_PERSIST : SEL_LOAD;
                        out_sel_d = 7'b1000000 >> bus.cmd_op;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = 4'(RESULT_LAT);
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_d  = RESP;
                    rv_d     = 1'b1;
                    in_sel_d = SEL_PERSIST;
                    rd_d     = (op_q == OP_CLR) ? '0 : alu_result;
                    re_d     = alu_overflow && (op_q == OP_MUL);
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rv_d = 1'b0;
                    if (en) begin
                        state_d = IDLE;
                    end else begin
                        state_d = OFF;
                        on_d    = 1'b0;
                    end
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= OFF;
            op_q          <= '0;
            cnt           <= '0;
            alu_on        <= 1'b0;
            alu_in_sel    <= SEL_RESET;
            alu_num1      <= '0;
            alu_num2      <= '0;
            alu_out_sel   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state         <= state_d;
            op_q          <= op_d;
            cnt           <= cnt_d;
            alu_on        <= on_d;
            alu_in_sel    <= in_sel_d;
            alu_num1      <= num1_d;
            alu_num2      <= num2_d;
            alu_out_sel   <= out_sel_d;
            bus.rsp_valid <= rv_d;
            bus.rsp_data  <= rd_d;
            bus.rsp_err   <= re_d;
        end
    end

`ifdef ALU_SEQ_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count  <= '0;
            err_count <= '0;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
            if (bus.rsp_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural accumulator-ALU stand-in.
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic rst, en;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.WIDTH(8)) bus();

    logic       alu_on, alu_overflow;
    logic [2:0] alu_in_sel;
    logic [7:0] alu_num1, alu_num2, alu_result;
    logic [6:0] alu_out_sel;
`ifdef ALU_SEQ_CNT_EN
    logic [15:0] op_count;
    logic [7:0]  err_count;
`endif

    logic [7:0]  acc, opa;
    logic [15:0] prod;
    logic        ovf_force;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc;

    alu_cmd_sequencer #(.RESULT_LAT(1), .WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .bus          (bus),
        .alu_on       (alu_on),
        .alu_in_sel   (alu_in_sel),
        .alu_num1     (alu_num1),
        .alu_num2     (alu_num2),
        .alu_out_sel  (alu_out_sel),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow)
`ifdef ALU_SEQ_CNT_EN
        ,
        .op_count     (op_count),
        .err_count    (err_count)
`endif
    );

    // ALU stand-in: accumulator value is set by the stimulus after each op
    always_comb begin
        opa          = alu_in_sel[2] ? acc : alu_num1;
        prod         = 16'(opa) * 16'(alu_num2);
        alu_overflow = ovf_force;
        alu_result   = 8'h5A;
        case (alu_out_sel)
            7'b1000000: alu_result = opa & alu_num2;
            7'b0100000: alu_result = opa | alu_num2;
            7'b0010000: alu_result = ~opa;
            7'b0001000: alu_result = opa ^ alu_num2;
            7'b0000100: alu_result = opa + alu_num2;
            7'b0000010: alu_result = opa - alu_num2;
            7'b0000001: alu_result = prod[7:0];
            default:    alu_result = 8'h5A;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic c, input logic [7:0] a, input logic [7:0] b);
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'h1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_chain = c;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.rsp_valid) break;
        end
        if (!bus.rsp_valid) chk("rsp_timeout", 32'(bus.rsp_valid), 32'h1);
    endtask

    task automatic ack();
        @(posedge clk); #1;
        chk("rsp_ack", 32'(bus.rsp_valid), 32'h0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; ovf_force = 1'b0; acc = 8'h00;
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_chain = 1'b0;
        bus.cmd_a = 8'h00; bus.cmd_b = 8'h00; bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_alu_on", 32'(alu_on), 32'h0);
        chk("rst_in_sel", 32'(alu_in_sel), 32'h1);
        chk("rst_out_sel", 32'(alu_out_sel), 32'h0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);

        rst = 1'b1;
        @(posedge clk); #1;
        chk("off_alu_on", 32'(alu_on), 32'h0);
        en = 1'b1;
        @(posedge clk); #1;
        chk("idle_alu_on", 32'(alu_on), 32'h1);
        chk("idle_in_sel", 32'(alu_in_sel), 32'h4);

        // ADD with latency check
        issue(3'd4, 1'b0, 8'h25, 8'h13);
        chk("add_out_sel", 32'(alu_out_sel), 32'h04);
        chk("add_in_sel", 32'(alu_in_sel), 32'h2);
        chk("add_num1", 32'(alu_num1), 32'h25);
        chk("add_num2", 32'(alu_num2), 32'h13);
        wait_rsp(cyc);
        chk("add_latency", 32'(cyc), 32'd2);
        chk("add_data", 32'(bus.rsp_data), 32'h38);
        chk("add_err", 32'(bus.rsp_err), 32'h0);
        ack();
        acc = 8'h38;

        // Chained ADD then SUB on accumulator
        issue(3'd4, 1'b0, 8'h10, 8'h05);
        wait_rsp(cyc);
        chk("chain_add_data", 32'(bus.rsp_data), 32'h15);
        ack();
        acc = 8'h15;
        issue(3'd5, 1'b1, 8'h99, 8'h03);
        chk("chain_sub_in_sel", 32'(alu_in_sel), 32'h4);
        chk("chain_sub_out_sel", 32'(alu_out_sel), 32'h02);
        wait_rsp(cyc);
        chk("chain_sub_data", 32'(bus.rsp_data), 32'h12);
        ack();
        acc = 8'h12;

        // MUL overflow, then AND with overflow line still high
        ovf_force = 1'b1;
        issue(3'd6, 1'b0, 8'h20, 8'h10);
        chk("mul_out_sel", 32'(alu_out_sel), 32'h01);
        wait_rsp(cyc);
        chk("mul_data", 32'(bus.rsp_data), 32'h00);
        chk("mul_err", 32'(bus.rsp_err), 32'h1);
        ack();
        issue(3'd0, 1'b0, 8'hF0, 8'h3C);
        wait_rsp(cyc);
        chk("and_data", 32'(bus.rsp_data), 32'h30);
        chk("and_err", 32'(bus.rsp_err), 32'h0);
        ack();
        ovf_force = 1'b0;

        // Backpressure on NOT
        bus.rsp_ready = 1'b0;
        issue(3'd2, 1'b0, 8'h0F, 8'h00);
        chk("not_out_sel", 32'(alu_out_sel), 32'h10);
        wait_rsp(cyc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("bp_data", 32'(bus.rsp_data), 32'hF0);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        end
        bus.rsp_ready = 1'b1;
        ack();
        chk("bp_release_ready", 32'(bus.cmd_ready), 32'h1);

        // en dropped in WAIT: response still delivered, then OFF
        issue(3'd1, 1'b0, 8'h0A, 8'h41);
        @(posedge clk); #1;
        en = 1'b0;
        wait_rsp(cyc);
        chk("endrop_data", 32'(bus.rsp_data), 32'h4B);
        ack();
        chk("endrop_alu_on", 32'(alu_on), 32'h0);
        chk("endrop_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        en = 1'b1;
        @(posedge clk); #1;
        chk("reen_alu_on", 32'(alu_on), 32'h1);
        issue(3'd7, 1'b0, 8'h33, 8'h44);
        chk("clr_in_sel", 32'(alu_in_sel), 32'h1);
        chk("clr_out_sel", 32'(alu_out_sel), 32'h0);
        wait_rsp(cyc);
        chk("clr_data", 32'(bus.rsp_data), 32'h00);
        chk("clr_err", 32'(bus.rsp_err), 32'h0);
        ack();
        acc = 8'h00;
`ifdef ALU_SEQ_CNT_EN
        chk("op_count", 32'(op_count), 32'd8);
        chk("err_count", 32'(err_count), 32'd1);
`endif

        // Reset pulsed during WAIT
        issue(3'd3, 1'b0, 8'hFF, 8'h0F);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("wrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("wrst_in_sel", 32'(alu_in_sel), 32'h1);
        chk("wrst_alu_on", 32'(alu_on), 32'h0);
        chk("wrst_out_sel", 32'(alu_out_sel), 32'h0);
        chk("wrst_num1", 32'(alu_num1), 32'h0);
        chk("wrst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
`ifdef ALU_SEQ_CNT_EN
        chk("wrst_op_count", 32'(op_count), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("wrst_no_rsp", 32'(bus.rsp_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
